// File: rtl/fb_rect_writer_if.sv
// Command and pixel-write bus between the render FSM, the rectangle
// writer engine and the frame buffer write port.
interface fb_rect_writer_if;
    // command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_clear;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [7:0]  cmd_h;
    logic [2:0]  cmd_color;
    // frame buffer write channel
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ready;

    // issuer of commands and owner of the frame buffer memory
    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_ready,
        input  cmd_ready, wr_en, wr_addr, wr_data
    );

    // the writer engine
    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_ready,
        output cmd_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill / screen-clear write engine for the 3-bit render frame
// buffer. Emits one pixel write per accepted cycle in row-major order,
// addr = y*PX_WIDTH + x, with rectangles clipped to the screen.
module fb_rect_writer #(
    parameter int PX_WIDTH  = 160,
    parameter int PX_HEIGHT = 120
) (
    input  logic              clk,
    input  logic              clr,
    fb_rect_writer_if.slave   bus,
    output logic              busy,
    output logic              done
);

    localparam logic [8:0]  W9  = 9'(PX_WIDTH);
    localparam logic [8:0]  H9  = 9'(PX_HEIGHT);
    localparam logic [15:0] W16 = 16'(PX_WIDTH);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t      state, state_nxt;
    logic [8:0]  x, y, x0, x1, y1;
    logic [15:0] addr, row_start;
    logic [2:0]  color;

    logic        accept, fire, last_col, last_px, empty;
    logic [8:0]  bx0, by0, bx1, by1, sx, sy;
    logic [15:0] start_addr;

    // Clipped bounds and start address of the command on the bus
    always_comb begin
        sx    = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
        sy    = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
        bx0   = '0;
        by0   = '0;
        bx1   = W9;
        by1   = H9;
        empty = 1'b0;
        if (!bus.cmd_clear) begin
            bx0   = {1'b0, bus.cmd_x};
            by0   = {1'b0, bus.cmd_y};
            bx1   = (sx > W9) ? W9 : sx;
            by1   = (sy > H9) ? H9 : sy;
            empty = (bus.cmd_w == '0) || (bus.cmd_h == '0) || (bx0 >= W9) || (by0 >= H9);
        end
        start_addr = 16'(by0) * W16 + 16'(bx0);
    end

    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign fire     = (state == DRAW) && bus.wr_ready;
    assign last_col = (x == x1 - 9'd1);
    assign last_px  = last_col && (y == y1 - 9'd1);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.wr_en     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (accept) state_nxt = empty ? DONE : DRAW;
            end
            DRAW: begin
                bus.wr_en = 1'b1;
                busy      = 1'b1;
                if (fire && last_px) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster walker: row base is stepped by PX_WIDTH so the loop needs no multiply
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            x         <= '0;
            y         <= '0;
            x0        <= '0;
            x1        <= '0;
            y1        <= '0;
            addr      <= '0;
            row_start <= '0;
            color     <= '0;
        end else if (accept) begin
            x         <= bx0;
            y         <= by0;
            x0        <= bx0;
            x1        <= bx1;
            y1        <= by1;
            addr      <= start_addr;
            row_start <= start_addr;
            color     <= bus.cmd_color;
        end else if (fire && !last_px) begin
            if (last_col) begin
                x         <= x0;
                y         <= y + 9'd1;
                row_start <= row_start + W16;
                addr      <= row_start + W16;
            end else begin
                x    <= x + 9'd1;
                addr <= addr + 16'd1;
            end
        end
    end

    assign bus.wr_addr = addr;
    assign bus.wr_data = color;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: directed scenarios plus random
// rectangles compared against a nested-loop raster model.
module tb_fb_rect_writer;

    localparam int W = 160;
    localparam int H = 120;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic busy, done;

    fb_rect_writer_if bus ();

    fb_rect_writer #(.PX_WIDTH(W), .PX_HEIGHT(H)) dut (
        .clk  (clk),
        .clr  (clr),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // observation state
    logic [15:0] got_addr[$];
    logic [2:0]  got_data[$];
    int          got_cyc[$];
    int          exp_q[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stall_cnt = 0;
    int          hold_viol = 0;
    int          acc_cyc = 0;
    logic        ready_after;
    int          rdy_mode = 0;
    int          bp_left = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr;
    logic [2:0]  prev_data;

    // monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
            got_addr.push_back(bus.wr_addr);
            got_data.push_back(bus.wr_data);
            got_cyc.push_back(cyc);
        end
        if (prev_stall && bus.wr_en === 1'b1 &&
            (bus.wr_addr !== prev_addr || bus.wr_data !== prev_data))
            hold_viol++;
        if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b0) stall_cnt++;
        prev_stall = (bus.wr_en === 1'b1) && (bus.wr_ready === 1'b0);
        prev_addr  = bus.wr_addr;
        prev_data  = bus.wr_data;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    // wr_ready driver: 0 = always ready, 1 = random, 2 = stall 3 cycles on 2nd pixel
    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: bus.wr_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (bus.wr_en === 1'b1 && got_addr.size() == 1 && bp_left > 0) begin
                        bus.wr_ready = 1'b0;
                        bp_left--;
                    end else begin
                        bus.wr_ready = 1'b1;
                    end
                end
                default: bus.wr_ready = 1'b1;
            endcase
        end
    end

    // reference raster: every on-screen pixel of the command, row-major
    function automatic void build_exp(input bit c, input int cx, input int cy,
                                      input int cw, input int ch);
        exp_q.delete();
        if (c) begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++) exp_q.push_back(yy * W + xx);
        end else begin
            for (int yy = cy; yy < cy + ch && yy < H; yy++)
                for (int xx = cx; xx < cx + cw && xx < W; xx++) exp_q.push_back(yy * W + xx);
        end
    endfunction

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        done_cnt  = 0;
        stall_cnt = 0;
        hold_viol = 0;
        bp_left   = 3;
    endtask

    task automatic drive_cmd(input bit c, input int cx, input int cy, input int cw,
                             input int ch, input int col);
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = c;
        bus.cmd_x     = 8'(cx);
        bus.cmd_y     = 8'(cy);
        bus.cmd_w     = 8'(cw);
        bus.cmd_h     = 8'(ch);
        bus.cmd_color = 3'(col);
    endtask

    // issue one command and wait (bounded) for its done pulse
    task automatic run_cmd(input bit c, input int cx, input int cy, input int cw,
                           input int ch, input int col, output bit ok);
        int n;
        clear_obs();
        @(posedge clk);
        #1;
        drive_cmd(c, cx, cy, cw, ch, col);
        ok = 0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) ok = 1;
            n++;
        end
        if (!ok) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc       = cyc;
        bus.cmd_valid = 1'b0;
        ok = 0;
        n  = 0;
        while (!ok && n < 25000) begin
            @(posedge clk);
            if (done_cnt > 0) ok = 1;
            n++;
        end
        #1;
        ready_after = bus.cmd_ready;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({bus.wr_en, busy, done} !== 3'b000) $display("FAIL reset_ctrl: wr_en/busy/done=%b expected 000", {bus.wr_en, busy, done});
        else n_pass++;
        n_total++;
        if (bus.wr_addr !== 16'd0 || bus.wr_data !== 3'd0) $display("FAIL reset_bus: addr=%0d data=%0d expected 0 0", bus.wr_addr, bus.wr_data);
        else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_total++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: cmd_ready=%b expected 1", bus.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_rect();
        bit ok;
        int ea[4];
        ea = '{643, 644, 803, 804};
        rdy_mode = 0;
        run_cmd(1'b0, 3, 4, 2, 2, 5, ok);
        n_total++;
        if (!ok || got_addr.size() != 4) $display("FAIL rect_count: ok=%0d writes=%0d expected 1 4", ok, got_addr.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            n_total++;
            if (int'(got_addr[i]) != ea[i] || got_data[i] !== 3'd5) $display("FAIL rect_px%0d: addr=%0d data=%0d expected %0d 5", i, got_addr[i], got_data[i], ea[i]);
            else n_pass++;
        end
        n_total++;
        if (got_addr.size() < 1 || got_cyc[0] != acc_cyc) $display("FAIL rect_latency: first write cyc=%0d expected %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, acc_cyc);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || done_cyc != acc_cyc + 4) $display("FAIL rect_done: count=%0d cyc=%0d expected 1 %0d", done_cnt, done_cyc, acc_cyc + 4);
        else n_pass++;
        n_total++;
        if (ready_after !== 1'b1) $display("FAIL rect_ready_after: cmd_ready=%b expected 1", ready_after);
        else n_pass++;
    endtask

    task automatic test_clip();
        bit ok;
        rdy_mode = 0;
        run_cmd(1'b0, 158, 119, 5, 4, 6, ok);
        n_total++;
        if (!ok || got_addr.size() != 2) $display("FAIL clip_count: ok=%0d writes=%0d expected 1 2", ok, got_addr.size());
        else n_pass++;
        n_total++;
        if (got_addr.size() < 2 || got_addr[0] !== 16'd19198 || got_addr[1] !== 16'd19199)
            $display("FAIL clip_addr: first=%0d second=%0d expected 19198 19199",
                     (got_addr.size() > 0) ? int'(got_addr[0]) : -1, (got_addr.size() > 1) ? int'(got_addr[1]) : -1);
        else n_pass++;
        n_total++;
        if (done_cnt != 1) $display("FAIL clip_done: count=%0d expected 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_empty();
        bit ok;
        int cx[2];
        int cw[2];
        cx = '{5, 200};
        cw = '{0, 4};
        rdy_mode = 0;
        for (int k = 0; k < 2; k++) begin
            run_cmd(1'b0, cx[k], 7, cw[k], 3, 1, ok);
            n_total++;
            if (!ok || got_addr.size() != 0) $display("FAIL empty%0d_writes: ok=%0d writes=%0d expected 1 0", k, ok, got_addr.size());
            else n_pass++;
            n_total++;
            if (done_cnt != 1 || done_cyc != acc_cyc) $display("FAIL empty%0d_done: count=%0d cyc=%0d expected 1 %0d", k, done_cnt, done_cyc, acc_cyc);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        rdy_mode = 2;
        run_cmd(1'b0, 0, 0, 3, 1, 3, ok);
        rdy_mode = 0;
        n_total++;
        if (!ok || got_addr.size() != 3) $display("FAIL bp_count: ok=%0d writes=%0d expected 1 3", ok, got_addr.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
            n_total++;
            if (int'(got_addr[i]) != i || got_data[i] !== 3'd3) $display("FAIL bp_px%0d: addr=%0d data=%0d expected %0d 3", i, got_addr[i], got_data[i], i);
            else n_pass++;
        end
        n_total++;
        if (stall_cnt != 3 || hold_viol != 0) $display("FAIL bp_hold: stalls=%0d hold_violations=%0d expected 3 0", stall_cnt, hold_viol);
        else n_pass++;
        n_total++;
        if (done_cyc != acc_cyc + 6) $display("FAIL bp_done_cyc: cyc=%0d expected %0d", done_cyc, acc_cyc + 6);
        else n_pass++;
    endtask

    task automatic test_clear();
        bit ok;
        int bad;
        int first_bad;
        rdy_mode = 0;
        run_cmd(1'b1, 9, 9, 1, 1, 2, ok);
        build_exp(1'b1, 0, 0, 0, 0);
        n_total++;
        if (!ok || got_addr.size() != exp_q.size()) $display("FAIL clear_count: ok=%0d writes=%0d expected 1 %0d", ok, got_addr.size(), exp_q.size());
        else n_pass++;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < got_addr.size() && i < exp_q.size(); i++)
            if (int'(got_addr[i]) != exp_q[i] || got_data[i] !== 3'd2) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        n_total++;
        if (bad != 0) $display("FAIL clear_content: %0d bad writes, first at index %0d expected 0 bad", bad, first_bad);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || done_cyc != acc_cyc + W * H) $display("FAIL clear_done: count=%0d cyc=%0d expected 1 %0d", done_cnt, done_cyc, acc_cyc + W * H);
        else n_pass++;
    endtask

    task automatic test_clr_abort();
        bit ok;
        int n;
        int nw;
        int bad;
        rdy_mode = 0;
        clear_obs();
        @(posedge clk);
        #1;
        drive_cmd(1'b1, 0, 0, 0, 0, 4);
        ok = 0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) ok = 1;
            n++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (got_addr.size() < 100 && n < 400) begin
            @(posedge clk);
            n++;
        end
        n_total++;
        if (got_addr.size() < 100) $display("FAIL abort_progress: writes=%0d expected >=100", got_addr.size());
        else n_pass++;
        #3;
        clr = 1'b1;
        #1;
        n_total++;
        if (bus.wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_async: wr_en/busy/done=%b%b%b expected 000", bus.wr_en, busy, done);
        else n_pass++;
        n_total++;
        if (bus.wr_addr !== 16'd0) $display("FAIL abort_addr: addr=%0d expected 0", bus.wr_addr);
        else n_pass++;
        nw = got_addr.size();
        repeat (2) @(posedge clk);
        #2;
        clr = 1'b0;
        repeat (5) @(posedge clk);
        n_total++;
        if (got_addr.size() != nw || done_cnt != 0) $display("FAIL abort_quiet: writes=%0d done=%0d expected %0d 0", got_addr.size(), done_cnt, nw);
        else n_pass++;
        run_cmd(1'b0, 10, 10, 3, 2, 7, ok);
        build_exp(1'b0, 10, 10, 3, 2);
        bad = (got_addr.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_addr.size() && i < exp_q.size(); i++)
            if (int'(got_addr[i]) != exp_q[i] || got_data[i] !== 3'd7) bad++;
        n_total++;
        if (!ok || bad != 0 || got_cyc.size() == 0 || got_cyc[0] != acc_cyc)
            $display("FAIL abort_next_cmd: ok=%0d bad=%0d writes=%0d first_addr=%0d expected 1 0 6 1610",
                     ok, bad, got_addr.size(), (got_addr.size() > 0) ? int'(got_addr[0]) : -1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        int bad;
        int qa[$];
        rdy_mode = 0;
        clear_obs();
        build_exp(1'b0, 20, 30, 4, 2);
        qa = exp_q;
        build_exp(1'b0, 100, 50, 2, 3);
        qa = {qa, exp_q};
        @(posedge clk);
        #1;
        drive_cmd(1'b0, 20, 30, 4, 2, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.cmd_ready !== 1'b1 && n < 20);
        @(posedge clk);
        #1;
        // second command presented while the first is still drawing
        drive_cmd(1'b0, 100, 50, 2, 3, 6);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.cmd_ready !== 1'b1 && n < 40);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (done_cnt < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        bad = (got_addr.size() != qa.size()) ? 1 : 0;
        for (int i = 0; i < got_addr.size() && i < qa.size(); i++)
            if (int'(got_addr[i]) != qa[i] || got_data[i] !== ((i < 8) ? 3'd1 : 3'd6)) bad++;
        n_total++;
        if (bad != 0) $display("FAIL b2b_writes: bad=%0d writes=%0d expected 0 %0d", bad, got_addr.size(), qa.size());
        else n_pass++;
        n_total++;
        if (done_cnt != 2) $display("FAIL b2b_done: count=%0d expected 2", done_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int cx, cy, cw, ch, col, bad;
        for (int it = 0; it < 24; it++) begin
            cx  = $urandom_range(0, 170);
            cy  = $urandom_range(0, 130);
            cw  = $urandom_range(0, 12);
            ch  = $urandom_range(0, 12);
            col = $urandom_range(0, 7);
            if (it % 4 == 3) begin
                cx = $urandom_range(150, 159);
                cy = $urandom_range(110, 119);
            end
            rdy_mode = (it % 2 == 0) ? 0 : 1;
            run_cmd(1'b0, cx, cy, cw, ch, col, ok);
            rdy_mode = 0;
            build_exp(1'b0, cx, cy, cw, ch);
            bad = 0;
            for (int i = 0; i < got_addr.size() && i < exp_q.size(); i++)
                if (int'(got_addr[i]) != exp_q[i] || int'(got_data[i]) != col) bad++;
            n_total++;
            if (!ok || got_addr.size() != exp_q.size() || bad != 0 || done_cnt != 1 || hold_viol != 0)
                $display("FAIL rand%0d (x=%0d y=%0d w=%0d h=%0d): ok=%0d writes=%0d bad=%0d done=%0d hold=%0d expected 1 %0d 0 1 0",
                         it, cx, cy, cw, ch, ok, got_addr.size(), bad, done_cnt, hold_viol, exp_q.size());
            else n_pass++;
            if (it % 2 == 0) begin
                n_total++;
                if (done_cyc != acc_cyc + exp_q.size()) $display("FAIL rand%0d_timing: done cyc=%0d expected %0d", it, done_cyc, acc_cyc + exp_q.size());
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        test_reset();
        test_rect();
        test_clip();
        test_empty();
        test_backpressure();
        test_clear();
        test_clr_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
